pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: synchronous active-high reset (`RstEnable` = 1'b1).
REQ-003 The module SHALL have the port stallreq_id, input, 1 bit: decode stage requests a stall, such as a load-use hazard.
REQ-004 The module SHALL have the port stallreq_ex, input, 1 bit: execute stage requests a single-cycle stall.
REQ-005 The module SHALL have the port mc_start, input, 1 bit: execute stage begins a multi-cycle operation, such as multiply-accumulate.
REQ-006 The module SHALL have the port mc_cycles, input, 6 bits: the number of extra execute cycles the operation needs, sampled with mc_start.
REQ-007 The module SHALL have the port excp_valid, input, 1 bit: the memory stage signals an exception.
REQ-008 The module SHALL have the port excp_handler, input, `RegBus` (32 bits): the handler PC, sampled with excp_valid.
REQ-009 The module SHALL have the port stall, output, 6 bits: per-stage hold, with bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 wb.
REQ-010 The module SHALL have the port flush, output, 1 bit: clears all pipeline registers, including ex_mem, to reset values.
REQ-011 The module SHALL have the port new_pc, output, `RegBus`: the redirect target, valid while flush=1.
REQ-012 The module SHALL have the port mc_busy, output, 1 bit: a multi-cycle operation is in progress.

Function
REQ-013 The controller SHALL implement exactly three states:
- RUN;
- MC (multi-cycle hold);
- FLUSH.
REQ-014 stall SHALL be combinational from the current state and the request inputs, so that a request holds the pipeline in the same cycle it is raised.
REQ-015 flush, new_pc and mc_busy SHALL be registered outputs.
REQ-016 In RUN, stall SHALL be selected by this priority:
- excp_valid=1 gives 6'b000000;
- otherwise, mc_start=1 with mc_cycles != 0 gives 6'b001111;
- otherwise, stallreq_ex=1 gives 6'b001111;
- otherwise, stallreq_id=1 gives 6'b000111;
- otherwise stall is 6'b000000.
REQ-017 In RUN, excp_valid=1 SHALL make the next state FLUSH and latch excp_handler into new_pc, with flush=1 in the following cycle.
REQ-018 In RUN, mc_start=1 with mc_cycles=K (K>=1) and no exception SHALL load the down-counter with K and make the next state MC.
REQ-019 mc_start=1 with mc_cycles=0 SHALL produce no stall and no state change.
REQ-020 In MC, stall SHALL be 6'b001111 and mc_busy SHALL be 1.
REQ-021 In MC, the counter SHALL decrement each cycle, and the state SHALL return to RUN in the cycle after the counter equals 1.
REQ-022 A K-cycle multi-cycle operation SHALL therefore produce exactly K+1 consecutive stall cycles, counting the mc_start cycle.
REQ-023 In MC, mc_start, stallreq_ex and stallreq_id SHALL be ignored.
REQ-024 In MC, excp_valid=1 SHALL abort the operation:
- the counter is cleared to 0;
- mc_busy goes to 0 at the next edge;
- the next state is FLUSH, with new_pc latched;
- stall is 6'b000000 in the exception cycle.
REQ-025 In FLUSH, flush SHALL be 1 and stall SHALL be 6'b000000 for exactly one cycle, after which the state returns to RUN.
REQ-026 excp_valid=1 while in FLUSH SHALL remain in FLUSH for one more cycle and re-latch new_pc from excp_handler.
REQ-027 stall requests raised during a FLUSH cycle SHALL be ignored, because the flushed stages hold no valid instruction.
REQ-028 The counter SHALL never underflow: a counter value of 0 in MC SHALL force a transition to RUN.
REQ-029 new_pc SHALL hold its last value outside FLUSH.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL set:
- state to RUN;
- the counter to 0;
- flush to 0;
- new_pc to `ZeroWord`;
- mc_busy to 0.
REQ-031 While rst=1, stall SHALL be forced to 6'b000000 regardless of the request inputs.
REQ-032 A reset asserted mid-MC or mid-FLUSH SHALL abandon the operation, with no residual stall or flush after rst deasserts.

Structure
REQ-034 The state encodings, the stall masks (`StallNone` 6'b000000, `StallId` 6'b000111, `StallEx` 6'b001111) and `StallBus` 5:0 SHALL be defined in the shared defines file.
REQ-035 The block SHALL be a single module with no sub-module; the counter and the state register are local.

Verification
REQ-036 The bench SHALL cover a decode stall: stallreq_id=1 for 2 cycles in RUN -> stall=6'b000111 in exactly those 2 cycles and flush=0 throughout.
REQ-037 The bench SHALL cover a multi-cycle operation: mc_start=1 with mc_cycles=3 -> stall=6'b001111 for 4 consecutive cycles, mc_busy=1 for cycles 2-4, and RUN with stall=0 in cycle 5.
REQ-038 The bench SHALL cover an exception: excp_valid=1 with excp_handler=32'h0000_0040 -> in the next cycle, flush=1, new_pc=32'h0000_0040 and stall=0; in the cycle after that, flush=0.
REQ-039 The bench SHALL cover an abort: excp_valid=1 with handler 32'h0000_0080 in the second MC cycle of a mc_cycles=5 operation -> stall=0 in that cycle, flush=1 in the next, mc_busy=0, and no further stall.
REQ-040 The bench SHALL cover simultaneous requests: stallreq_id, stallreq_ex and mc_start (mc_cycles=0) all 1 in one RUN cycle -> stall=6'b001111 and the state remains RUN.
REQ-041 The bench SHALL cover reset during MC: rst=1 in the second MC cycle of mc_cycles=4 -> stall=0 in that cycle and all outputs at reset values after the edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline controller: reset polarity, bus widths,
// per-stage stall masks and the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam logic        RstEnable = 1'b1;

    localparam int          REG_W     = 32;
    localparam int          STALL_W   = 6;   // StallBus 5:0
    localparam int          MC_CNT_W  = 6;

    typedef logic [REG_W-1:0]    reg_t;
    typedef logic [STALL_W-1:0]  stall_t;
    typedef logic [MC_CNT_W-1:0] mc_cnt_t;

    localparam reg_t   ZeroWord  = '0;

    // Stall masks: bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 wb.
    localparam stall_t StallNone = 6'b000000;
    localparam stall_t StallId   = 6'b000111;  // hold pc, if/id, id/ex
    localparam stall_t StallEx   = 6'b001111;  // additionally hold ex/mem

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MC    = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the pipeline-control request and response signals.
//   stallreq_id  : decode stage stall request (e.g. load-use hazard)
//   stallreq_ex  : execute stage single-cycle stall request
//   mc_start     : execute stage starts a multi-cycle operation
//   mc_cycles    : extra execute cycles needed, sampled with mc_start
//   excp_valid   : memory stage exception
//   excp_handler : handler PC, sampled with excp_valid
//   stall        : per-stage hold mask (combinational)
//   flush        : clear all pipeline registers (registered)
//   new_pc       : redirect target, valid while flush=1 (registered)
//   mc_busy      : multi-cycle operation in progress (registered)
// master : pipeline side (drives requests, consumes controls)
// slave  : controller side
// -----------------------------------------------------------------------------
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic    stallreq_id;
    logic    stallreq_ex;
    logic    mc_start;
    mc_cnt_t mc_cycles;
    logic    excp_valid;
    reg_t    excp_handler;
    stall_t  stall;
    logic    flush;
    reg_t    new_pc;
    logic    mc_busy;

    modport master (
        output stallreq_id, stallreq_ex, mc_start, mc_cycles, excp_valid, excp_handler,
        input  stall, flush, new_pc, mc_busy
    );

    modport slave (
        input  stallreq_id, stallreq_ex, mc_start, mc_cycles, excp_valid, excp_handler,
        output stall, flush, new_pc, mc_busy
    );

endinterface

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline hazard / exception controller with three states:
//   RUN   - normal flow, stall chosen by request priority
//   MC    - multi-cycle execute hold, driven by a down-counter
//   FLUSH - one-cycle flush with redirect to the exception handler
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : pipe_ctrl_if.slave (requests in, stall/flush/new_pc/mc_busy out)
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus
);

    state_e  state_q,   state_d;
    mc_cnt_t cnt_q,     cnt_d;
    reg_t    new_pc_q,  new_pc_d;
    logic    flush_q,   flush_d;
    logic    mc_busy_q, mc_busy_d;
    stall_t  stall_c;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            new_pc_q  <= ZeroWord;
            flush_q   <= 1'b0;
            mc_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            new_pc_q  <= new_pc_d;
            flush_q   <= flush_d;
            mc_busy_q <= mc_busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        new_pc_d = new_pc_q;
        stall_c  = StallNone;

        unique case (state_q)
            ST_RUN: begin
                // Exception wins: the excepting instruction is flushed, so holding
                // any stage would only delay the redirect.
                if (bus.excp_valid) begin
                    state_d  = ST_FLUSH;
                    new_pc_d = bus.excp_handler;
                end else if (bus.mc_start && (bus.mc_cycles != '0)) begin
                    stall_c = StallEx;
                    cnt_d   = bus.mc_cycles;
                    state_d = ST_MC;
                end else if (bus.stallreq_ex) begin
                    stall_c = StallEx;
                end else if (bus.stallreq_id) begin
                    stall_c = StallId;
                end
            end

            ST_MC: begin
                if (bus.excp_valid) begin
                    cnt_d    = '0;
                    state_d  = ST_FLUSH;
                    new_pc_d = bus.excp_handler;
                end else begin
                    stall_c = StallEx;
                    // <=1 rather than ==1 so a zero count can never wrap.
                    if (cnt_q <= mc_cnt_t'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - mc_cnt_t'(1);
                    end
                end
            end

            ST_FLUSH: begin
                // Flushed stages hold no valid instruction, so stall requests
                // are dropped; a back-to-back exception re-arms the flush.
                if (bus.excp_valid) begin
                    new_pc_d = bus.excp_handler;
                end else begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
        endcase

        if (rst == RstEnable) begin
            stall_c = StallNone;
        end
    end

    // Registered outputs mirror the next state so they line up with it.
    assign flush_d   = (state_d == ST_FLUSH);
    assign mc_busy_d = (state_d == ST_MC);

    assign bus.stall   = stall_c;
    assign bus.flush   = flush_q;
    assign bus.new_pc  = new_pc_q;
    assign bus.mc_busy = mc_busy_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    typedef struct {
        string  tag;
        stall_t stall;
        logic   flush;
        reg_t   new_pc;
        logic   mc_busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive inputs just after the edge, push what the cycle
    // must show, then sample mid-cycle and compare against the popped entry.
    task automatic step(input string tag, input logic r, input logic id, input logic ex,
                        input logic mcs, input logic [5:0] mcc, input logic ev,
                        input logic [31:0] eh, input logic [5:0] e_stall,
                        input logic e_flush, input logic [31:0] e_pc, input logic e_busy);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.stallreq_id  = id;
        bus.stallreq_ex  = ex;
        bus.mc_start     = mcs;
        bus.mc_cycles    = mcc;
        bus.excp_valid   = ev;
        bus.excp_handler = eh;
        e.tag = tag; e.stall = e_stall; e.flush = e_flush; e.new_pc = e_pc; e.mc_busy = e_busy;
        sb.push_back(e);
        #3;
        e = sb.pop_front();
        n_cmp++;
        assert (bus.stall === e.stall) else begin
            n_err++; $error("FAIL %s stall: got %b expected %b", e.tag, bus.stall, e.stall);
        end
        n_cmp++;
        assert (bus.flush === e.flush) else begin
            n_err++; $error("FAIL %s flush: got %b expected %b", e.tag, bus.flush, e.flush);
        end
        n_cmp++;
        assert (bus.new_pc === e.new_pc) else begin
            n_err++; $error("FAIL %s new_pc: got %h expected %h", e.tag, bus.new_pc, e.new_pc);
        end
        n_cmp++;
        assert (bus.mc_busy === e.mc_busy) else begin
            n_err++; $error("FAIL %s mc_busy: got %b expected %b", e.tag, bus.mc_busy, e.mc_busy);
        end
    endtask

    initial begin
        bus.stallreq_id = 1'b0; bus.stallreq_ex = 1'b0; bus.mc_start = 1'b0;
        bus.mc_cycles = '0; bus.excp_valid = 1'b0; bus.excp_handler = '0;

        //    tag          rst id ex mcs mcc ev eh             stall      fl pc            busy
        // reset forces stall low even with requests present
        step("rst_req",    1, 1, 1, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h0,        0);
        step("idle0",      0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h0,        0);
        // decode stall for 2 cycles
        step("id_c1",      0, 1, 0, 0, 0, 0, 32'h0,         6'b000111, 0, 32'h0,        0);
        step("id_c2",      0, 1, 0, 0, 0, 0, 32'h0,         6'b000111, 0, 32'h0,        0);
        step("id_end",     0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h0,        0);
        // mc_cycles=3: 4 stall cycles, requests ignored inside MC
        step("mc3_c1",     0, 0, 0, 1, 3, 0, 32'h0,         6'b001111, 0, 32'h0,        0);
        step("mc3_c2",     0, 1, 0, 1, 7, 0, 32'h0,         6'b001111, 0, 32'h0,        1);
        step("mc3_c3",     0, 0, 1, 0, 0, 0, 32'h0,         6'b001111, 0, 32'h0,        1);
        step("mc3_c4",     0, 0, 0, 0, 0, 0, 32'h0,         6'b001111, 0, 32'h0,        1);
        step("mc3_c5",     0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h0,        0);
        // exception, stall requests ignored during flush
        step("exc_c1",     0, 0, 0, 0, 0, 1, 32'h40,        6'b000000, 0, 32'h0,        0);
        step("exc_fl",     0, 1, 1, 0, 0, 0, 32'h0,         6'b000000, 1, 32'h40,       0);
        step("exc_end",    0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h40,       0);
        // simultaneous requests with mc_cycles=0: stays in RUN
        step("sim_c1",     0, 1, 1, 1, 0, 0, 32'h0,         6'b001111, 0, 32'h40,       0);
        step("sim_c2",     0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h40,       0);
        step("mc0",        0, 0, 0, 1, 0, 0, 32'h0,         6'b000000, 0, 32'h40,       0);
        step("ex_only",    0, 0, 1, 0, 0, 0, 32'h0,         6'b001111, 0, 32'h40,       0);
        step("ex_end",     0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h40,       0);
        // abort mc_cycles=5 in the second MC cycle
        step("ab_start",   0, 0, 0, 1, 5, 0, 32'h0,         6'b001111, 0, 32'h40,       0);
        step("ab_mc1",     0, 0, 0, 0, 0, 0, 32'h0,         6'b001111, 0, 32'h40,       1);
        step("ab_exc",     0, 1, 1, 0, 0, 1, 32'h80,        6'b000000, 0, 32'h40,       1);
        step("ab_fl",      0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 1, 32'h80,       0);
        step("ab_run1",    0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h80,       0);
        step("ab_run2",    0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h80,       0);
        // back-to-back exceptions extend flush and re-latch new_pc
        step("bb_c1",      0, 0, 0, 0, 0, 1, 32'h100,       6'b000000, 0, 32'h80,       0);
        step("bb_c2",      0, 0, 0, 0, 0, 1, 32'h200,       6'b000000, 1, 32'h100,      0);
        step("bb_c3",      0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 1, 32'h200,      0);
        step("bb_end",     0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h200,      0);
        // exception has priority over mc_start and stallreq_ex
        step("pri_c1",     0, 0, 1, 1, 2, 1, 32'h300,       6'b000000, 0, 32'h200,      0);
        step("pri_fl",     0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 1, 32'h300,      0);
        step("pri_end",    0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h300,      0);
        // shortest multi-cycle op: K=1 gives 2 stall cycles
        step("k1_c1",      0, 0, 0, 1, 1, 0, 32'h0,         6'b001111, 0, 32'h300,      0);
        step("k1_c2",      0, 0, 0, 0, 0, 0, 32'h0,         6'b001111, 0, 32'h300,      1);
        step("k1_c3",      0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h300,      0);
        // reset in the second MC cycle of mc_cycles=4
        step("rmc_start",  0, 0, 0, 1, 4, 0, 32'h0,         6'b001111, 0, 32'h300,      0);
        step("rmc_mc1",    0, 0, 0, 0, 0, 0, 32'h0,         6'b001111, 0, 32'h300,      1);
        step("rmc_rst",    1, 1, 1, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h300,      1);
        step("rmc_after",  0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h0,        0);
        step("rmc_idle",   0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h0,        0);
        // reset during FLUSH
        step("rfl_exc",    0, 0, 0, 0, 0, 1, 32'h44,        6'b000000, 0, 32'h0,        0);
        step("rfl_rst",    1, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 1, 32'h44,       0);
        step("rfl_after",  0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h0,        0);
        step("rfl_idle",   0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 0, 32'h0,        0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
